ttl74x194: RTL



---
 rtl/ttl_defs_pkg.sv | 10 +
 rtl/ttl194_bit.sv | 38 +++
 rtl/ttl74x194.sv | 32 +++
 3 files changed

// File: rtl/ttl_defs_pkg.sv
// Shared mode encodings for the TTL-style datapath parts.
// {s1,s0} select values for the 74x194 universal shift register.
package ttl_defs;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/ttl194_bit.sv
// One bit slice of the 74x194: 4:1 next-state mux plus a clear-able flip-flop.
// lower is the neighbour one bit below (shift-right source), upper the one above.
module ttl194_bit
    import ttl_defs::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] s,
    input  logic       lower,
    input  logic       upper,
    input  logic       d,
    output logic       q
);

    logic next;

    always_comb begin
        // NOTE: next gets a value before the case, so no branch can leave it unassigned and infer a latch.
        next = q;
        case (s)
            MODE_HOLD: next = q;
            MODE_SHR:  next = lower;
            MODE_SHL:  next = upper;
            MODE_LOAD: next = d;
            default:   next = 1'bx;
        endcase
    end

    // NOTE: non-blocking so every slice samples its neighbours' pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q <= 1'b0;
        end else begin
            q <= next;
        end
    end

endmodule

// File: rtl/ttl74x194.sv
// 74x194 bidirectional universal shift register, widened by WIDTH (must be >= 2).
// Cascade: q[WIDTH-1] feeds the next stage's dsr; that stage's q[0] feeds this dsl.
module ttl74x194 #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [1:0]       s,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Serial inputs padded onto both ends so every slice sees plain neighbours.
    logic [WIDTH+1:0] chain;

    assign chain = {dsl, q, dsr};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ttl194_bit u_bit (
            .clock (clock),
            .clear (clear),
            .s     (s),
            .lower (chain[i]),
            .upper (chain[i+2]),
            .d     (d[i]),
            .q     (q[i])
        );
    end

endmodule
